// File: rtl/passcode_pkg.sv
// Shared types and constants for the passcode lock controller.
// Digit i of a stored code lives at bits [DIGIT_W*i +: DIGIT_W].
package passcode_pkg;

  localparam int DIGIT_W = 5;
  localparam int MAX_SEQ = 8;
  localparam int IDX_W   = 3;
  localparam int TRY_W   = 4;

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    EVAL     = 2'd1,
    UNLOCKED = 2'd2,
    LOCKOUT  = 2'd3
  } lock_state_t;

endpackage

// File: rtl/passcode_lock_timer.sv
// Loadable down-counter shared by the UNLOCKED and LOCKOUT states.
// Load wins over decrement; the count saturates at zero.
module lock_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/passcode_lock_fsm.sv
// Passcode lock controller: entry check, timed unlock, lockout, reprogramming.
// Outputs are a registered view of the internal state, one edge behind it.
module passcode_lock_fsm
  import passcode_pkg::*;
#(
  parameter int                         SEQ_LEN        = 2,
  parameter logic [SEQ_LEN*DIGIT_W-1:0] DEFAULT_CODE   = 10'd547,
  parameter int                         MAX_TRIES      = 3,
  parameter int                         UNLOCK_CYCLES  = 16,
  parameter int                         LOCKOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIGIT_W-1:0] code_in,
  input  logic               code_valid,
  input  logic               code_invalid,
  input  logic               prog_en,
  input  logic               relock,
  output logic               unlocked,
  output logic               lockout,
  output logic               alarm,
  output logic               match_pulse,
  output logic               fail_pulse,
  output logic               prog_done,
  output logic [TRY_W-1:0]   tries_left,
  output logic [IDX_W-1:0]   digit_idx
);

  localparam int CODE_W = SEQ_LEN * DIGIT_W;
  localparam int TMAX   = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ?
                          UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TW     = $clog2(TMAX);

  localparam logic [IDX_W-1:0] LAST  = IDX_W'(SEQ_LEN - 1);
  localparam logic [TRY_W-1:0] TRIES = TRY_W'(MAX_TRIES);
  localparam logic [TW-1:0]    T_UNL = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0]    T_LKO = TW'(LOCKOUT_CYCLES - 1);

  lock_state_t        state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic               mm_q, mm_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic [CODE_W-1:0]  shadow_q, shadow_d;
  logic               match_q, match_d;
  logic               fail_q, fail_d;
  logic               alarm_q, alarm_d;
  logic               prog_q, prog_d;
  logic               t_load, t_en, t_zero;
  logic [TW-1:0]      t_val;
  logic [DIGIT_W-1:0] cur_digit;

  assign cur_digit = code_q[int'(idx_q)*DIGIT_W +: DIGIT_W];

  lock_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .en       (t_en),
    .zero     (t_zero)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tries_d  = tries_q;
    mm_d     = mm_q;
    code_d   = code_q;
    shadow_d = shadow_q;
    match_d  = 1'b0;
    fail_d   = 1'b0;
    alarm_d  = 1'b0;
    prog_d   = 1'b0;
    t_load   = 1'b0;
    t_val    = '0;
    t_en     = 1'b0;
    unique case (state_q)
      LOCKED: begin
        if (code_valid) begin
          mm_d = mm_q | code_invalid | (code_in != cur_digit);
          if (idx_q == LAST) begin
            idx_d   = '0;
            state_d = EVAL;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      EVAL: begin
        mm_d = 1'b0;
        unique case (1'b1)
          !mm_q: begin
            match_d = 1'b1;
            tries_d = TRIES;
            state_d = UNLOCKED;
            t_load  = 1'b1;
            t_val   = T_UNL;
          end
          mm_q && (tries_q > 4'd1): begin
            fail_d  = 1'b1;
            tries_d = tries_q - 1'b1;
            state_d = LOCKED;
          end
          mm_q && (tries_q <= 4'd1): begin
            fail_d  = 1'b1;
            alarm_d = 1'b1;
            tries_d = '0;
            state_d = LOCKOUT;
            t_load  = 1'b1;
            t_val   = T_LKO;
          end
          default: state_d = LOCKED;
        endcase
      end
      UNLOCKED: begin
        t_en = 1'b1;
        // Leaving discards any half-written program sequence.
        if (relock || t_zero) begin
          state_d = LOCKED;
          idx_d   = '0;
        end else if (prog_en && code_valid && !code_invalid) begin
          shadow_d[int'(idx_q)*DIGIT_W +: DIGIT_W] = code_in;
          if (idx_q == LAST) begin
            code_d = shadow_d;
            prog_d = 1'b1;
            idx_d  = '0;
            t_load = 1'b1;
            t_val  = T_UNL;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      LOCKOUT: begin
        t_en = 1'b1;
        if (t_zero) begin
          state_d = LOCKED;
          tries_d = TRIES;
        end
      end
      default: state_d = LOCKED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= LOCKED;
      idx_q    <= '0;
      tries_q  <= TRIES;
      mm_q     <= 1'b0;
      code_q   <= DEFAULT_CODE;
      shadow_q <= '0;
      match_q  <= 1'b0;
      fail_q   <= 1'b0;
      alarm_q  <= 1'b0;
      prog_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tries_q  <= tries_d;
      mm_q     <= mm_d;
      code_q   <= code_d;
      shadow_q <= shadow_d;
      match_q  <= match_d;
      fail_q   <= fail_d;
      alarm_q  <= alarm_d;
      prog_q   <= prog_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unlocked    <= 1'b0;
      lockout     <= 1'b0;
      alarm       <= 1'b0;
      match_pulse <= 1'b0;
      fail_pulse  <= 1'b0;
      prog_done   <= 1'b0;
      tries_left  <= TRIES;
      digit_idx   <= '0;
    end else begin
      unlocked    <= (state_q == UNLOCKED);
      lockout     <= (state_q == LOCKOUT);
      alarm       <= alarm_q;
      match_pulse <= match_q;
      fail_pulse  <= fail_q;
      prog_done   <= prog_q;
      tries_left  <= tries_q;
      digit_idx   <= idx_q;
    end
  end

endmodule

// File: tb/tb_passcode_lock_fsm.sv
// Self-checking bench for passcode_lock_fsm against a
// transaction-level model of stored code and remaining tries.
module tb_passcode_lock_fsm;

  localparam int MAX_TRIES = 3;
  localparam int UNL_CYC   = 16;
  localparam int LKO_CYC   = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] code_in;
  logic       code_valid;
  logic       code_invalid;
  logic       prog_en;
  logic       relock;
  logic       unlocked;
  logic       lockout;
  logic       alarm;
  logic       match_pulse;
  logic       fail_pulse;
  logic       prog_done;
  logic [3:0] tries_left;
  logic [2:0] digit_idx;

  int n_checks = 0;
  int n_fail   = 0;

  int m_code[2];
  int m_tries;
  bit m_unl;
  bit m_lko;

  passcode_lock_fsm dut (
    .clk          (clk),
    .rst          (rst),
    .code_in      (code_in),
    .code_valid   (code_valid),
    .code_invalid (code_invalid),
    .prog_en      (prog_en),
    .relock       (relock),
    .unlocked     (unlocked),
    .lockout      (lockout),
    .alarm        (alarm),
    .match_pulse  (match_pulse),
    .fail_pulse   (fail_pulse),
    .prog_done    (prog_done),
    .tries_left   (tries_left),
    .digit_idx    (digit_idx)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_code[0] = 3;
    m_code[1] = 17;
    m_tries   = MAX_TRIES;
    m_unl     = 0;
    m_lko     = 0;
  endtask

  // Returns at the falling edge right after the sampling edge.
  task automatic send(input int d, input bit inv, input int gap);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    code_in      = 5'(d);
    code_valid   = 1'b1;
    code_invalid = inv;
    @(negedge clk);
    code_valid   = 1'b0;
    code_invalid = 1'b0;
  endtask

  // Full entry; returns at the sample where the verdict is visible.
  task automatic entry(input int a, input int b, input bit inv);
    bit ok;
    int et;
    ok = !inv && a == m_code[0] && b == m_code[1];
    if (ok) et = MAX_TRIES;
    else if (m_tries > 1) et = m_tries - 1;
    else et = 0;
    send(a, inv, $urandom_range(0, 3));
    send(b, 1'b0, $urandom_range(0, 3));
    @(negedge clk);
    n_checks++;
    if (match_pulse !== 1'b0 || fail_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL entry_early got m=%b f=%b want 0 0",
               match_pulse, fail_pulse);
    end
    @(negedge clk);
    m_tries = et;
    m_unl   = ok;
    m_lko   = !ok && et == 0;
    n_checks++;
    if (match_pulse !== ok || fail_pulse !== !ok) begin
      n_fail++;
      $display("FAIL entry_pulse %0d,%0d got m=%b f=%b want %b %b",
               a, b, match_pulse, fail_pulse, ok, !ok);
    end
    n_checks++;
    if (alarm !== m_lko || lockout !== m_lko || unlocked !== ok) begin
      n_fail++;
      $display("FAIL entry_state got a=%b l=%b u=%b want %b %b %b",
               alarm, lockout, unlocked, m_lko, m_lko, ok);
    end
    n_checks++;
    if (tries_left !== 4'(et)) begin
      n_fail++;
      $display("FAIL entry_tries got %0d want %0d", tries_left, et);
    end
  endtask

  task automatic do_relock();
    @(negedge clk);
    relock = 1'b1;
    @(negedge clk);
    relock = 1'b0;
    @(negedge clk);
    m_unl = 0;
    n_checks++;
    if (unlocked !== 1'b0) begin
      n_fail++;
      $display("FAIL relock got unlocked=%b want 0", unlocked);
    end
  endtask

  task automatic wait_lockout();
    int n;
    n = 0;
    while (lockout === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    m_tries = MAX_TRIES;
    m_lko   = 0;
    n_checks++;
    if (n != LKO_CYC || tries_left !== 4'(MAX_TRIES)) begin
      n_fail++;
      $display("FAIL lockout_len got %0d/%0d want %0d/%0d",
               n, tries_left, LKO_CYC, MAX_TRIES);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    code_in = '0;
    code_valid = 1'b0;
    code_invalid = 1'b0;
    prog_en = 1'b0;
    relock = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({unlocked, lockout, alarm, match_pulse, fail_pulse,
         prog_done} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 000000",
               {unlocked, lockout, alarm, match_pulse,
                fail_pulse, prog_done});
    end
    n_checks++;
    if (tries_left !== 4'd3 || digit_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_cnt got t=%0d i=%0d want 3 0",
               tries_left, digit_idx);
    end
  endtask

  task automatic test_unlock();
    int n;
    entry(3, 17, 1'b0);
    n = 0;
    while (unlocked === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      if (n == 1) begin
        n_checks++;
        if (match_pulse !== 1'b0) begin
          n_fail++;
          $display("FAIL match_width got %b want 0", match_pulse);
        end
      end
    end
    m_unl = 0;
    n_checks++;
    if (n != UNL_CYC || tries_left !== 4'd3) begin
      n_fail++;
      $display("FAIL unlock_len got %0d/%0d want %0d/3",
               n, tries_left, UNL_CYC);
    end
  endtask

  task automatic test_single_fail();
    entry(3, 18, 1'b0);
    entry(3, 17, 1'b0);
    do_relock();
  endtask

  task automatic test_lockout();
    int n;
    bit seen;
    entry(5, 5, 1'b0);
    entry(5, 5, 1'b0);
    entry(5, 5, 1'b0);
    n = 0;
    seen = 0;
    while (lockout === 1'b1 && n < 200) begin
      n++;
      if (unlocked === 1'b1 || match_pulse === 1'b1) seen = 1;
      @(negedge clk);
      code_valid = (n == 5 || n == 8);
      code_in    = (n == 5) ? 5'd3 : 5'd17;
    end
    code_valid = 1'b0;
    m_tries = MAX_TRIES;
    m_lko = 0;
    n_checks++;
    if (n != LKO_CYC || seen) begin
      n_fail++;
      $display("FAIL lockout_len got %0d seen=%b want %0d 0",
               n, seen, LKO_CYC);
    end
    n_checks++;
    if (tries_left !== 4'd3 || digit_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL lockout_exit got t=%0d i=%0d want 3 0",
               tries_left, digit_idx);
    end
    entry(3, 17, 1'b0);
    do_relock();
  endtask

  task automatic test_invalid();
    entry(3, 17, 1'b1);
    entry(3, 17, 1'b0);
    do_relock();
  endtask

  task automatic test_program();
    int n;
    entry(3, 17, 1'b0);
    prog_en = 1'b1;
    send(9, 1'b0, 0);
    @(negedge clk);
    n_checks++;
    if (digit_idx !== 3'd1) begin
      n_fail++;
      $display("FAIL prog_idx got %0d want 1", digit_idx);
    end
    send(20, 1'b1, 0);
    @(negedge clk);
    n_checks++;
    if (digit_idx !== 3'd1 || prog_done !== 1'b0) begin
      n_fail++;
      $display("FAIL prog_drop got i=%0d p=%b want 1 0",
               digit_idx, prog_done);
    end
    send(30, 1'b0, 0);
    @(negedge clk);
    prog_en = 1'b0;
    n_checks++;
    if (prog_done !== 1'b1) begin
      n_fail++;
      $display("FAIL prog_done got %b want 1", prog_done);
    end
    m_code[0] = 9;
    m_code[1] = 30;
    n = 0;
    while (unlocked === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    m_unl = 0;
    n_checks++;
    if (n != UNL_CYC) begin
      n_fail++;
      $display("FAIL prog_timer got %0d want %0d", n, UNL_CYC);
    end
    entry(3, 17, 1'b0);
    entry(9, 30, 1'b0);
    do_relock();
  endtask

  task automatic test_reset_mid();
    entry(m_code[0], m_code[1], 1'b0);
    prog_en = 1'b1;
    send(1, 1'b0, 0);
    @(negedge clk);
    n_checks++;
    if (digit_idx !== 3'd1) begin
      n_fail++;
      $display("FAIL mid_idx got %0d want 1", digit_idx);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (unlocked !== 1'b0 || digit_idx !== 3'd0 ||
        tries_left !== 4'd3 || lockout !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst got u=%b i=%0d t=%0d l=%b want 0 0 3 0",
               unlocked, digit_idx, tries_left, lockout);
    end
    @(negedge clk);
    rst = 1'b0;
    prog_en = 1'b0;
    model_reset();
    entry(3, 17, 1'b0);
    do_relock();
  endtask

  task automatic test_random();
    int a;
    int b;
    bit inv;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        a = m_code[0];
        b = m_code[1];
      end else begin
        a = $urandom_range(0, 31);
        b = $urandom_range(0, 31);
      end
      inv = ($urandom_range(0, 7) == 0);
      entry(a, b, inv);
      if (m_unl) do_relock();
      else if (m_lko) wait_lockout();
    end
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_single_fail();
    test_lockout();
    test_invalid();
    test_program();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/passcode_lock_fsm.md
Name: passcode_lock_fsm

Overview:
Sequential lock controller directly downstream of the passcode converter. It consumes 5-bit passcode digits, one per valid strobe, and compares a SEQ_LEN-digit entry against a stored code. It then grants a timed unlock, counts failed attempts, and enforces a lockout with an alarm pulse. While unlocked, the stored code can be reprogrammed.

Parameters:
SEQ_LEN, 2, number of 5-bit digits per code entry (1..8)
DEFAULT_CODE, 10'd547, reset value of the stored code. Digit i occupies bits [5i+4:5i]; digit 0 is entered first. 547 = digits 3, 17.
MAX_TRIES, 3, failed entries allowed before lockout (1..15)
UNLOCK_CYCLES, 16, cycles spent UNLOCKED before auto-relock (>=2)
LOCKOUT_CYCLES, 64, cycles spent in LOCKOUT (>=2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
code_in  input  5  passcode digit from the converter
code_valid  input  1  code_in is valid this cycle (single-cycle strobe per digit)
code_invalid  input  1  converter flagged out-of-range input; qualified by code_valid
prog_en  input  1  while UNLOCKED, valid digits are written into the stored code instead of relocking
relock  input  1  force UNLOCKED -> LOCKED
unlocked  output  1  high in UNLOCKED
lockout  output  1  high in LOCKOUT
alarm  output  1  one-cycle pulse on entry to LOCKOUT
match_pulse  output  1  one-cycle pulse: entry matched
fail_pulse  output  1  one-cycle pulse: entry mismatched
prog_done  output  1  one-cycle pulse: new code committed
tries_left  output  4  remaining attempts
digit_idx  output  3  digits accepted in the current entry or program sequence

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous and active-high.
- Reset values: state=LOCKED, stored code=DEFAULT_CODE, tries_left=MAX_TRIES, digit_idx=0, timers=0, all pulses and flags 0.
- All outputs are registered.
- States are LOCKED, EVAL, UNLOCKED, LOCKOUT.
- LOCKED, digit accept:
  - On code_valid, compare code_in against stored digit[digit_idx], then increment digit_idx.
  - A sticky mismatch flag is set on inequality, or if code_invalid=1; an invalid digit always counts as a mismatch.
- LOCKED, last digit: when digit_idx==SEQ_LEN-1 and code_valid, go to EVAL. digit_idx returns to 0.
- EVAL (exactly 1 cycle); ignores code_valid.
  - No mismatch: match_pulse, tries_left<=MAX_TRIES, go to UNLOCKED.
  - Mismatch with tries_left>1: fail_pulse, tries_left-1, go to LOCKED.
  - Mismatch with tries_left==1: fail_pulse and alarm, tries_left<=0, go to LOCKOUT.
  - The mismatch flag is cleared in all cases.
- Latency: pulses and state outputs assert on the 2nd rising edge after the edge that samples the last digit.
- UNLOCKED: the timer loads UNLOCK_CYCLES on entry and decrements every cycle.
  - Exit to LOCKED when the timer reaches 0 or relock=1 (relock wins same cycle).
  - Any partial program sequence is discarded on exit.
- Programming (UNLOCKED, prog_en=1, code_valid=1):
  - Write code_in into a shadow register at digit_idx, then increment digit_idx.
  - On the last digit, copy shadow to the stored code, pulse prog_done, and reset the timer to UNLOCK_CYCLES.
  - A digit with code_invalid=1 is dropped and does not advance digit_idx.
  - The stored code never holds a partial update.
- UNLOCKED with code_valid and prog_en=0: ignored.
- LOCKOUT: code_valid is ignored. The timer loads LOCKOUT_CYCLES and counts to 0, then goes to LOCKED with tries_left<=MAX_TRIES. relock has no effect.
- Gaps between digits are unlimited; there is no inter-digit timeout.
- An asynchronous rst mid-entry, mid-program or mid-lockout restores all reset values immediately, including the stored code.

Decomposition:
- Shared package passcode_pkg holds:
  - the state enum (LOCKED, EVAL, UNLOCKED, LOCKOUT)
  - DIGIT_W=5 and digit-slice helper constants
- One sub-module, lock_timer: a loadable down-counter with load value, enable, and a zero flag. It is instantiated once and shared by UNLOCKED and LOCKOUT, since the states are exclusive.

Test Plan:
- Correct entry: digits 3 then 17 after reset -> match_pulse 2 edges after digit 17, unlocked=1 for 16 cycles, then unlocked=0, tries_left=3.
- Single failure: digits 3, 18 -> fail_pulse, tries_left=2, stays LOCKED. Then 3, 17 -> unlocked=1, tries_left=3.
- Lockout: three wrong entries (5,5) -> third produces fail_pulse plus alarm, lockout=1 for 64 cycles. Digits 3,17 entered during lockout are ignored. Afterwards tries_left=3.
- Invalid digit: digit 3 with code_invalid=1, then 17 -> fail_pulse, tries_left=2.
- Reprogram: unlock, then prog_en=1 with digits 9, 30 -> prog_done, timer restarted. After relock, 3,17 fails and 9,30 matches.
- Reset mid-operation: assert rst after the first digit of a program sequence -> all outputs return to reset values asynchronously, and code 3,17 unlocks again.
